// File: rtl/psk_iq_corr_engine_pkg.sv
// ============================================================================
// Module   : psk_iq_corr_engine_pkg
// Brief    : Shared defaults and width helpers for the PSK I/Q correlator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package psk_iq_corr_engine_pkg;

  localparam int          C_NCO_W_DEF   = 12;
  localparam int          C_WIN_LEN_DEF = 256;
  localparam logic [11:0] C_FCW_RST_DEF = 12'h100;
  localparam logic [11:0] C_PCW_RST_DEF = 12'h000;

  // Signed correlation width: must hold -WIN_LEN..+WIN_LEN and |I|+|Q| <= 2*WIN_LEN
  function automatic int corr_width(input int win_len);
    return $clog2(win_len) + 2;
  endfunction

  // +90 degree offset in phase-accumulator units
  function automatic int quarter_turn(input int nco_w);
    return 1 << (nco_w - 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/psk_iq_corr_engine_corr_acc.sv
// ============================================================================
// Module   : psk_iq_corr_engine_corr_acc
// Brief    : Per-window XNOR match counter; presents 2*matches-WIN_LEN at window end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psk_iq_corr_engine_corr_acc
  import psk_iq_corr_engine_pkg::*;
#(
  parameter  int WIN_LEN = C_WIN_LEN_DEF,
  localparam int CORR_W  = corr_width(WIN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sig,
  input  logic                     ref_bit,
  input  logic                     win_end,
  output logic signed [CORR_W-1:0] corr
);

  localparam int ACC_W = $clog2(WIN_LEN) + 1;

  logic [ACC_W-1:0] r_matches;
  logic [ACC_W-1:0] w_total;
  logic             w_hit;

  assign w_hit   = en && (sig == ref_bit);
  // Includes the window-end sample itself, so the count restarts with nothing lost
  assign w_total = r_matches + ACC_W'(w_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matches <= '0;
    end else if (win_end) begin
      r_matches <= '0;
    end else if (w_hit) begin
      r_matches <= w_total;
    end
  end

  assign corr = $signed({w_total, 1'b0}) - $signed(CORR_W'(WIN_LEN));

endmodule

`default_nettype wire

// File: rtl/psk_iq_corr_engine.sv
// ============================================================================
// Module   : psk_iq_corr_engine
// Brief    : 1-bit I/Q correlator against quadrature NCO square references,
//            windowed results on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psk_iq_corr_engine
  import psk_iq_corr_engine_pkg::*;
#(
  parameter  int               NCO_W   = C_NCO_W_DEF,
  parameter  int               WIN_LEN = C_WIN_LEN_DEF,
  parameter  logic [NCO_W-1:0] FCW_RST = NCO_W'(C_FCW_RST_DEF),
  parameter  logic [NCO_W-1:0] PCW_RST = NCO_W'(C_PCW_RST_DEF),
  localparam int               CORR_W  = corr_width(WIN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     sig,
  input  logic                     cfg_ld,
  input  logic [NCO_W-1:0]         cfg_fcw,
  input  logic [NCO_W-1:0]         cfg_pcw,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [CORR_W-1:0] out_i,
  output logic signed [CORR_W-1:0] out_q,
  output logic [CORR_W-1:0]        out_mag,
  output logic                     out_ovf
);

  localparam int               CNT_W     = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WIN_LEN - 1);
  localparam logic [NCO_W-1:0] C_QUARTER = NCO_W'(quarter_turn(NCO_W));

  logic [NCO_W-1:0]         r_phase;
  logic [NCO_W-1:0]         r_fcw_act;
  logic [NCO_W-1:0]         r_pcw_act;
  logic [NCO_W-1:0]         r_fcw_sh;
  logic [NCO_W-1:0]         r_pcw_sh;
  logic [CNT_W-1:0]         r_cnt;

  logic                     r_out_valid;
  logic signed [CORR_W-1:0] r_out_i;
  logic signed [CORR_W-1:0] r_out_q;
  logic [CORR_W-1:0]        r_out_mag;
  logic                     r_out_ovf;

  logic [NCO_W-1:0]         w_iphase;
  logic [NCO_W-1:0]         w_qphase;
  logic                     w_iref;
  logic                     w_qref;
  logic                     w_win_end;
  logic                     w_xfer;
  logic                     w_unused;
  logic signed [CORR_W-1:0] w_corr_i;
  logic signed [CORR_W-1:0] w_corr_q;
  logic [CORR_W-1:0]        w_abs_i;
  logic [CORR_W-1:0]        w_abs_q;
  logic [CORR_W-1:0]        w_mag;

  assign w_iphase  = r_phase + r_pcw_act;
  assign w_qphase  = w_iphase + C_QUARTER;
  assign w_iref    = w_iphase[NCO_W-1];
  assign w_qref    = w_qphase[NCO_W-1];
  assign w_unused  = ^w_qphase[NCO_W-2:0];

  // Counter width is exact (WIN_LEN is a power of 2), so it wraps to 0 on its own
  assign w_win_end = en && (r_cnt == C_LAST);
  assign w_xfer    = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_cnt     <= '0;
      r_fcw_act <= FCW_RST;
      r_pcw_act <= PCW_RST;
      r_fcw_sh  <= FCW_RST;
      r_pcw_sh  <= PCW_RST;
    end else begin
      if (cfg_ld) begin
        r_fcw_sh <= cfg_fcw;
        r_pcw_sh <= cfg_pcw;
      end
      if (en) begin
        r_phase <= r_phase + r_fcw_act;
        r_cnt   <= r_cnt + 1'b1;
      end
      // Retune only between windows; a coincident load goes straight to the next window
      if (w_win_end) begin
        r_fcw_act <= cfg_ld ? cfg_fcw : r_fcw_sh;
        r_pcw_act <= cfg_ld ? cfg_pcw : r_pcw_sh;
      end
    end
  end

  psk_iq_corr_engine_corr_acc #(
    .WIN_LEN (WIN_LEN)
  ) u_acc_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sig     (sig),
    .ref_bit (w_iref),
    .win_end (w_win_end),
    .corr    (w_corr_i)
  );

  psk_iq_corr_engine_corr_acc #(
    .WIN_LEN (WIN_LEN)
  ) u_acc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sig     (sig),
    .ref_bit (w_qref),
    .win_end (w_win_end),
    .corr    (w_corr_q)
  );

  assign w_abs_i = w_corr_i[CORR_W-1] ? $unsigned(-w_corr_i) : $unsigned(w_corr_i);
  assign w_abs_q = w_corr_q[CORR_W-1] ? $unsigned(-w_corr_q) : $unsigned(w_corr_q);
  assign w_mag   = w_abs_i + w_abs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_mag   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_win_end) begin
      // Newest result wins; flag it if the previous one was never taken
      r_out_valid <= 1'b1;
      r_out_i     <= w_corr_i;
      r_out_q     <= w_corr_q;
      r_out_mag   <= w_mag;
      r_out_ovf   <= r_out_valid && !out_ready;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;
  assign out_mag   = r_out_mag;
  assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire
